// File: rtl/spi_pixel_tx_pkg.sv
// Shared definitions for the SPI pixel transmitter: FSM state encoding and
// the bit layout / idle values of the SPI pin synchronizer.
package spi_pixel_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        READY,
        SHIFT,
        DONE
    } spi_tx_state_t;

    // Bit positions of the SPI pins inside the synchronizer vectors
    localparam int SYNC_CLK_BIT = 0;
    localparam int SYNC_CS_BIT  = 1;

    // Idle bus levels: SPI_CLK low (mode 0), SPI_CS deasserted (high)
    localparam logic [1:0] SYNC_IDLE = 2'b10;

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous MCU pins SPI_CLK and SPI_CS into the clk domain
// through 2-FF synchronizers and derives single-cycle rise/fall pulses from
// the synchronized copies only.
module spi_sync_edge
    import spi_pixel_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic SPI_CLK,
    input  logic SPI_CS,
    output logic clk_rise,
    output logic clk_fall,
    output logic cs_level,
    output logic cs_rise,
    output logic cs_fall
);

    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] prev_q;

    // Two synchronizer stages plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= SYNC_IDLE;
            sync_q <= SYNC_IDLE;
            prev_q <= SYNC_IDLE;
        end else begin
            meta_q <= {SPI_CS, SPI_CLK};
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign clk_rise = sync_q[SYNC_CLK_BIT] & ~prev_q[SYNC_CLK_BIT];
    assign clk_fall = ~sync_q[SYNC_CLK_BIT] & prev_q[SYNC_CLK_BIT];
    assign cs_level = sync_q[SYNC_CS_BIT];
    assign cs_rise  = sync_q[SYNC_CS_BIT] & ~prev_q[SYNC_CS_BIT];
    assign cs_fall  = ~sync_q[SYNC_CS_BIT] & prev_q[SYNC_CS_BIT];

endmodule

// File: rtl/spi_pixel_tx.sv
// SPI mode-0 slave transmitter: streams one frame of pixel bytes from the
// pixel RAM to the MCU, MSB first, one byte per chip-select window. A byte
// aborted mid-way by the MCU is refetched and sent again in full.
module spi_pixel_tx
    import spi_pixel_tx_pkg::*;
#(
    parameter int IMAGE_SIZE       = 65536,
    parameter int IMAGE_ADDR_WIDTH = 16,
    parameter int RGB_SIZE         = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [IMAGE_ADDR_WIDTH-1:0] rd_addr,
    output logic                        rd_en,
    input  logic [RGB_SIZE-1:0]         rd_data,
    input  logic                        SPI_CLK,
    input  logic                        SPI_CS,
    output logic                        SPI_MISO,
    output logic                        miso_oe,
    output logic                        request_flag,
    output logic                        busy,
    output logic                        done
);

    localparam int BIT_CNT_WIDTH = $clog2(RGB_SIZE);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [BIT_CNT_WIDTH-1:0]    LAST_BIT  = BIT_CNT_WIDTH'(RGB_SIZE - 1);

    spi_tx_state_t               state;
    spi_tx_state_t               next_state;
    logic [IMAGE_ADDR_WIDTH-1:0] addr;
    logic [BIT_CNT_WIDTH-1:0]    bit_cnt;
    logic [RGB_SIZE-1:0]         shreg;
    logic                        byte_done;
    logic                        last_byte;

    logic clk_rise;
    logic clk_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;

    spi_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .SPI_CLK  (SPI_CLK),
        .SPI_CS   (SPI_CS),
        .clk_rise (clk_rise),
        .clk_fall (clk_fall),
        .cs_level (cs_level),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    assign rd_addr = addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state outputs
    always_comb begin
        next_state   = state;
        rd_en        = 1'b0;
        request_flag = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        miso_oe      = 1'b0;
        SPI_MISO     = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                next_state = READY;
            end
            READY: begin
                busy         = 1'b1;
                request_flag = 1'b1;
                SPI_MISO     = shreg[RGB_SIZE-1];
                if (cs_fall) next_state = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                SPI_MISO = shreg[RGB_SIZE-1];
                miso_oe  = ~cs_level;
                if (byte_done && (clk_fall || cs_rise)) begin
                    next_state = last_byte ? DONE : FETCH;
                end else if (cs_rise) begin
                    next_state = FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Address, bit counter and shift register; the address only advances
    // once all bits of a byte have been clocked out, so aborts refetch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            last_byte <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) addr <= '0;
                end
                LOAD: begin
                    shreg     <= rd_data;
                    bit_cnt   <= '0;
                    byte_done <= 1'b0;
                    last_byte <= 1'b0;
                end
                SHIFT: begin
                    if (!cs_rise && !byte_done) begin
                        if (clk_rise) begin
                            bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
                            if (bit_cnt == LAST_BIT) begin
                                byte_done <= 1'b1;
                                last_byte <= (addr == LAST_ADDR);
                                addr      <= addr + IMAGE_ADDR_WIDTH'(1);
                            end
                        end else if (clk_fall) begin
                            shreg <= {shreg[RGB_SIZE-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pixel_tx.sv
// Self-checking bench for spi_pixel_tx: an MCU model clocks bytes out at
// clk/8 and the received stream is compared with the RAM contents in order.
module tb_spi_pixel_tx;

    localparam int IMAGE_SIZE = 4;
    localparam int AW         = 16;
    localparam int RGB        = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [RGB-1:0] rd_data = '0;
    logic          SPI_CLK;
    logic          SPI_CS;
    logic          SPI_MISO;
    logic          miso_oe;
    logic          request_flag;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    int cs_high_run = 0;
    int oe_violations = 0;
    int oe_low_in_shift = 0;

    logic [7:0]    ram [0:15];
    logic [7:0]    rx_q [$];
    logic [AW-1:0] addr_q [$];

    spi_pixel_tx #(
        .IMAGE_SIZE       (IMAGE_SIZE),
        .IMAGE_ADDR_WIDTH (AW),
        .RGB_SIZE         (RGB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .SPI_CLK      (SPI_CLK),
        .SPI_CS       (SPI_CS),
        .SPI_MISO     (SPI_MISO),
        .miso_oe      (miso_oe),
        .request_flag (request_flag),
        .busy         (busy),
        .done         (done)
    );

    always #10 clk = ~clk;

    // Pixel RAM model: data valid one clock after the read strobe
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= ram[rd_addr[3:0]];
    end

    // Passive monitors: done pulses, fetched addresses, miso_oe while CS high
    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
        if (rd_en === 1'b1) addr_q.push_back(rd_addr);
        if (SPI_CS === 1'b1) cs_high_run++;
        else cs_high_run = 0;
        if (cs_high_run >= 4 && miso_oe !== 1'b0) oe_violations++;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // MCU model: waits for request_flag, lowers CS, clocks nbits at clk/8
    // sampling MISO on each rising edge, optionally raises CS afterwards
    task automatic mcu_byte(input int nbits, input bit raise_cs, output logic [7:0] b);
        int waited = 0;
        b = 8'h00;
        while (request_flag !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (request_flag !== 1'b1) begin
            errors++;
            $display("[TB] FAIL request_flag_timeout: got %b want 1 within 300 cycles", request_flag);
            return;
        end
        SPI_CS = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = {b[6:0], SPI_MISO};
            if (miso_oe !== 1'b1) oe_low_in_shift++;
            SPI_CLK = 1'b1;
            repeat (4) @(negedge clk);
            SPI_CLK = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (raise_cs) begin
            SPI_CS = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    // Whole frame; abort_idx selects the byte that first gets cut short
    task automatic run_frame(input int abort_idx, input int abort_bits);
        logic [7:0] b;
        rx_q.delete();
        addr_q.delete();
        pulse_start();
        for (int idx = 0; idx < IMAGE_SIZE; idx++) begin
            if (idx == abort_idx) mcu_byte(abort_bits, 1'b1, b);
            mcu_byte(8, 1'b1, b);
            rx_q.push_back(b);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        SPI_CLK = 1'b0;
        SPI_CS  = 1'b1;
        @(negedge clk);
        checks++; if (rd_addr !== '0)      begin errors++; $display("[TB] FAIL reset_rd_addr: got %h want 0", rd_addr); end
        checks++; if (rd_en !== 1'b0)      begin errors++; $display("[TB] FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (request_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_request_flag: got %b want 0", request_flag); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (SPI_MISO !== 1'b0)   begin errors++; $display("[TB] FAIL reset_miso: got %b want 0", SPI_MISO); end
        checks++; if (miso_oe !== 1'b0)    begin errors++; $display("[TB] FAIL reset_miso_oe: got %b want 0", miso_oe); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        logic [7:0] b;
        int d0;
        for (int i = 0; i < 4; i++) ram[i] = exp_bytes[i];
        d0 = done_count;
        oe_low_in_shift = 0;
        rx_q.delete();
        addr_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (rd_en !== 1'b1)  begin errors++; $display("[TB] FAIL latency_rd_en_c2: got %b want 1", rd_en); end
        checks++; if (rd_addr !== '0)  begin errors++; $display("[TB] FAIL latency_rd_addr_c2: got %h want 0", rd_addr); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("[TB] FAIL latency_busy_c2: got %b want 1", busy); end
        checks++; if (request_flag !== 1'b0) begin errors++; $display("[TB] FAIL latency_rf_c2: got %b want 0", request_flag); end
        @(negedge clk);
        checks++; if (rd_en !== 1'b0)  begin errors++; $display("[TB] FAIL latency_rd_en_c3: got %b want 0", rd_en); end
        checks++; if (request_flag !== 1'b0) begin errors++; $display("[TB] FAIL latency_rf_c3: got %b want 0", request_flag); end
        @(negedge clk);
        checks++; if (request_flag !== 1'b1) begin errors++; $display("[TB] FAIL latency_rf_c4: got %b want 1", request_flag); end
        for (int i = 0; i < 4; i++) begin
            mcu_byte(8, 1'b1, b);
            rx_q.push_back(b);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== exp_bytes[i]) begin
                errors++;
                $display("[TB] FAIL basic_byte%0d: got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_bytes[i]);
            end
        end
        checks++;
        if (addr_q.size() != 4) begin errors++; $display("[TB] FAIL basic_fetch_count: got %0d want 4", addr_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_q[i] !== AW'(i)) begin errors++; $display("[TB] FAIL basic_fetch_addr%0d: got %h want %h", i, addr_q[i], AW'(i)); end
        end
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_count - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
        checks++; if (oe_low_in_shift != 0) begin errors++; $display("[TB] FAIL basic_oe_in_shift: got %0d low samples want 0", oe_low_in_shift); end
    endtask

    task automatic test_abort();
        logic [AW-1:0] exp_addr [5] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};
        int d0 = done_count;
        run_frame(1, 3);
        checks++;
        if (rx_q.size() != 4) begin errors++; $display("[TB] FAIL abort_byte_count: got %0d want 4", rx_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q[i] !== ram[i]) begin errors++; $display("[TB] FAIL abort_byte%0d: got %h want %h", i, rx_q[i], ram[i]); end
        end
        checks++;
        if (addr_q.size() != 5) begin errors++; $display("[TB] FAIL abort_fetch_count: got %0d want 5", addr_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (addr_q[i] !== exp_addr[i]) begin errors++; $display("[TB] FAIL abort_fetch_addr%0d: got %h want %h", i, addr_q[i], exp_addr[i]); end
        end
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL abort_done_count: got %0d want 1", done_count - d0); end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] b;
        pulse_start();
        mcu_byte(8, 1'b1, b);
        mcu_byte(3, 1'b0, b);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rd_addr !== '0)        begin errors++; $display("[TB] FAIL midrst_rd_addr: got %h want 0", rd_addr); end
        checks++; if (rd_en !== 1'b0)        begin errors++; $display("[TB] FAIL midrst_rd_en: got %b want 0", rd_en); end
        checks++; if (request_flag !== 1'b0) begin errors++; $display("[TB] FAIL midrst_request_flag: got %b want 0", request_flag); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)         begin errors++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
        checks++; if (SPI_MISO !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_miso: got %b want 0", SPI_MISO); end
        checks++; if (miso_oe !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_miso_oe: got %b want 0", miso_oe); end
        @(negedge clk);
        SPI_CS = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_resume: busy got %b want 0", busy); end
        run_frame(-1, 0);
        checks++;
        if (addr_q.size() == 0 || addr_q[0] !== '0) begin
            errors++; $display("[TB] FAIL midrst_restart_addr: got %h want 0", (addr_q.size() > 0) ? addr_q[0] : 'x);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== ram[i]) begin
                errors++; $display("[TB] FAIL midrst_byte%0d: got %h want %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, ram[i]);
            end
        end
    endtask

    task automatic test_start_during_busy();
        logic [7:0] b;
        int d0 = done_count;
        rx_q.delete();
        addr_q.delete();
        pulse_start();
        mcu_byte(8, 1'b1, b);
        rx_q.push_back(b);
        pulse_start();
        for (int i = 1; i < 4; i++) begin
            mcu_byte(8, 1'b1, b);
            rx_q.push_back(b);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q[i] !== ram[i]) begin errors++; $display("[TB] FAIL busy_start_byte%0d: got %h want %h", i, rx_q[i], ram[i]); end
        end
        checks++; if (addr_q.size() != 4) begin errors++; $display("[TB] FAIL busy_start_fetch_count: got %0d want 4", addr_q.size()); end
        checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL busy_start_done_count: got %0d want 1", done_count - d0); end
    endtask

    task automatic test_clk_outside_shift();
        logic [7:0] b;
        addr_q.delete();
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            SPI_CLK = ~SPI_CLK;
            repeat ($urandom_range(4, 9)) @(negedge clk);
        end
        SPI_CLK = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL idle_clk_fetch: got %0d fetches want 0", addr_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_clk_busy: got %b want 0", busy); end
        pulse_start();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            SPI_CLK = ~SPI_CLK;
            repeat (5) @(negedge clk);
        end
        checks++; if (request_flag !== 1'b1) begin errors++; $display("[TB] FAIL ready_clk_rf: got %b want 1", request_flag); end
        checks++; if (addr_q.size() != 1) begin errors++; $display("[TB] FAIL ready_clk_fetch: got %0d fetches want 1", addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            mcu_byte(8, 1'b1, b);
            rx_q.push_back(b);
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q[i] !== ram[i]) begin errors++; $display("[TB] FAIL ready_clk_byte%0d: got %h want %h", i, rx_q[i], ram[i]); end
        end
        checks++; if (oe_violations != 0) begin errors++; $display("[TB] FAIL oe_while_cs_high: got %0d cycles want 0", oe_violations); end
    endtask

    task automatic test_random_frames();
        logic [AW-1:0] exp_addr [$];
        int abort_idx;
        int abort_bits;
        int d0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) ram[i] = 8'($urandom);
            abort_idx  = $urandom_range(0, 4);
            abort_bits = $urandom_range(1, 7);
            exp_addr.delete();
            for (int i = 0; i < 4; i++) begin
                exp_addr.push_back(AW'(i));
                if (i == abort_idx) exp_addr.push_back(AW'(i));
            end
            d0 = done_count;
            run_frame(abort_idx, abort_bits);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q.size() <= i || rx_q[i] !== ram[i]) begin
                    errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h want %h", k, i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, ram[i]);
                end
            end
            checks++;
            if (addr_q != exp_addr) begin
                errors++; $display("[TB] FAIL rand%0d_fetch_seq: got %0d fetches want %0d (abort byte %0d)", k, addr_q.size(), exp_addr.size(), abort_idx);
            end
            checks++; if (done_count - d0 != 1) begin errors++; $display("[TB] FAIL rand%0d_done_count: got %0d want 1", k, done_count - d0); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        test_reset();
        test_basic_frame();
        test_abort();
        test_reset_mid_shift();
        test_start_during_busy();
        test_clk_outside_shift();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
